// File: rtl/mbist_pkg.sv
// Shared definitions for the MBIST March C- sequencer: FSM and op encodings
// plus the March C- element table (direction, op count and op codes).
package mbist_pkg;

  localparam int NUM_ELEMS = 6;
  localparam int ELEM_W    = 3;

  // Index of the final element; reaching its sweep_done ends the test.
  localparam logic [ELEM_W-1:0] LAST_ELEM = 3'(NUM_ELEMS - 1);

  // Bit i describes element i: 1 = ascending sweep.
  localparam logic [NUM_ELEMS-1:0] ELEM_DIR_UP  = 6'b100111;
  // Bit i describes element i: 1 = two ops per address, 0 = one op.
  localparam logic [NUM_ELEMS-1:0] ELEM_TWO_OPS = 6'b011110;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ELEM_START = 2'd1,
    ST_RUN        = 2'd2,
    ST_DONE       = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_W0 = 2'd0,
    OP_W1 = 2'd1,
    OP_R0 = 2'd2,
    OP_R1 = 2'd3
  } op_t;

  // Sweep direction of an element; out-of-range indices default to ascending.
  function automatic logic elemDirUp(input logic [ELEM_W-1:0] elem);
    logic dirUp;
    dirUp = 1'b1;
    case (elem)
      3'd0:    dirUp = ELEM_DIR_UP[0];
      3'd1:    dirUp = ELEM_DIR_UP[1];
      3'd2:    dirUp = ELEM_DIR_UP[2];
      3'd3:    dirUp = ELEM_DIR_UP[3];
      3'd4:    dirUp = ELEM_DIR_UP[4];
      3'd5:    dirUp = ELEM_DIR_UP[5];
      default: dirUp = 1'b1;
    endcase
    return dirUp;
  endfunction

  // op_idx value of the element's final op at one address (0 or 1).
  function automatic logic elemLastOpIdx(input logic [ELEM_W-1:0] elem);
    logic lastIdx;
    lastIdx = 1'b0;
    case (elem)
      3'd0:    lastIdx = ELEM_TWO_OPS[0];
      3'd1:    lastIdx = ELEM_TWO_OPS[1];
      3'd2:    lastIdx = ELEM_TWO_OPS[2];
      3'd3:    lastIdx = ELEM_TWO_OPS[3];
      3'd4:    lastIdx = ELEM_TWO_OPS[4];
      3'd5:    lastIdx = ELEM_TWO_OPS[5];
      default: lastIdx = 1'b0;
    endcase
    return lastIdx;
  endfunction

  // March C-: {W0} up, {R0,W1} up, {R1,W0} up, {R0,W1} down, {R1,W0} down, {R0} up.
  function automatic op_t elemOp(input logic [ELEM_W-1:0] elem, input logic opIdx);
    op_t op;
    op = OP_R0;
    case (elem)
      3'd0:    op = OP_W0;
      3'd1:    op = opIdx ? OP_W1 : OP_R0;
      3'd2:    op = opIdx ? OP_W0 : OP_R1;
      3'd3:    op = opIdx ? OP_W1 : OP_R0;
      3'd4:    op = opIdx ? OP_W0 : OP_R1;
      3'd5:    op = OP_R0;
      default: op = OP_R0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mbist_rd_cmp.sv
// One-stage read compare: remembers what a read expects, checks the SRAM data
// one cycle later and keeps a sticky fail flag with the first failing location.
module mbist_rd_cmp
  import mbist_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_clear,
  input  logic                  i_rd,
  input  logic [DATA_WIDTH-1:0] i_exp,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [ELEM_W-1:0]     i_elem,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_fail,
  output logic [ADDR_WIDTH-1:0] o_fail_addr,
  output logic [ELEM_W-1:0]     o_fail_elem
);

  logic                  r_cmpValid;
  logic [DATA_WIDTH-1:0] r_exp;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ELEM_W-1:0]     r_elem;
  logic                  r_fail;
  logic [ADDR_WIDTH-1:0] r_failAddr;
  logic [ELEM_W-1:0]     r_failElem;
  logic                  w_miscompare;

  // Hold the expectation of a read issued this cycle until its data returns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmpValid <= 1'b0;
      r_exp      <= '0;
      r_addr     <= '0;
      r_elem     <= '0;
    end else begin
      r_cmpValid <= i_rd && !i_clear;
      if (i_rd) begin
        r_exp  <= i_exp;
        r_addr <= i_addr;
        r_elem <= i_elem;
      end
    end
  end

  assign w_miscompare = r_cmpValid && (i_rdata != r_exp);

  // Sticky fail; only the first miscompare of a run records its location.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fail     <= 1'b0;
      r_failAddr <= '0;
      r_failElem <= '0;
    end else if (i_clear) begin
      r_fail     <= 1'b0;
      r_failAddr <= '0;
      r_failElem <= '0;
    end else if (w_miscompare) begin
      r_fail <= 1'b1;
      if (!r_fail) begin
        r_failAddr <= r_addr;
        r_failElem <= r_elem;
      end
    end
  end

  assign o_fail      = r_fail;
  assign o_fail_addr = r_failAddr;
  assign o_fail_elem = r_failElem;

endmodule

// File: rtl/mbist_march_seq.sv
// March C- sequencer: walks the six elements, steering the address generator
// and issuing one SRAM op per cycle; read data is checked by mbist_rd_cmp.
module mbist_march_seq
  import mbist_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_fail,
  output logic [ADDR_WIDTH-1:0] o_fail_addr,
  output logic [2:0]            o_fail_elem,
  output logic                  o_start_elem,
  output logic                  o_dir_up,
  output logic                  o_addr_step,
  input  logic                  i_sweep_done,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_mem_ce,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  state_t            r_state;
  logic [ELEM_W-1:0] r_elem;
  logic              r_opIdx;
  logic              r_dirUp;

  state_t            w_stateNext;
  logic [ELEM_W-1:0] w_elemNext;
  logic              w_opIdxNext;
  logic              w_dirUpNext;
  op_t               w_op;
  logic              w_startElem;
  logic              w_memCe;
  logic              w_memWe;
  logic              w_wdataBit;
  logic              w_addrStep;
  logic              w_clear;
  logic              w_rd;
  logic              w_expBit;

  // State, element, op index and the element direction register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_elem  <= '0;
      r_opIdx <= 1'b0;
      r_dirUp <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_elem  <= w_elemNext;
      r_opIdx <= w_opIdxNext;
      r_dirUp <= w_dirUpNext;
    end
  end

  // Next-state logic and the Mealy memory/address-generator controls.
  // dir_up is loaded on entry to ELEM_START so the generator sees the new
  // direction together with start_elem.
  always_comb begin
    w_stateNext = r_state;
    w_elemNext  = r_elem;
    w_opIdxNext = r_opIdx;
    w_dirUpNext = r_dirUp;
    w_op        = elemOp(r_elem, r_opIdx);
    w_startElem = 1'b0;
    w_memCe     = 1'b0;
    w_memWe     = 1'b0;
    w_wdataBit  = 1'b0;
    w_addrStep  = 1'b0;
    w_clear     = 1'b0;
    w_rd        = 1'b0;
    w_expBit    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_clear     = 1'b1;
          w_elemNext  = '0;
          w_dirUpNext = elemDirUp('0);
          w_stateNext = ST_ELEM_START;
        end
      end

      ST_ELEM_START: begin
        w_startElem = 1'b1;
        w_opIdxNext = 1'b0;
        w_stateNext = ST_RUN;
      end

      ST_RUN: begin
        if (i_sweep_done) begin
          if (r_elem < LAST_ELEM) begin
            w_elemNext  = r_elem + 3'd1;
            w_dirUpNext = elemDirUp(r_elem + 3'd1);
            w_stateNext = ST_ELEM_START;
          end else begin
            w_stateNext = ST_DONE;
          end
        end else begin
          w_memCe = 1'b1;
          case (w_op)
            OP_W0: w_memWe = 1'b1;
            OP_W1: begin
              w_memWe    = 1'b1;
              w_wdataBit = 1'b1;
            end
            OP_R0: w_rd = 1'b1;
            OP_R1: begin
              w_rd     = 1'b1;
              w_expBit = 1'b1;
            end
            default: w_memWe = 1'b0;
          endcase
          if (r_opIdx == elemLastOpIdx(r_elem)) begin
            w_addrStep  = 1'b1;
            w_opIdxNext = 1'b0;
          end else begin
            w_opIdxNext = 1'b1;
          end
        end
      end

      ST_DONE: begin
        w_stateNext = ST_IDLE;
      end

      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  mbist_rd_cmp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rdCmp (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_clear     (w_clear),
    .i_rd        (w_rd),
    .i_exp       ({DATA_WIDTH{w_expBit}}),
    .i_addr      (i_addr),
    .i_elem      (r_elem),
    .i_rdata     (i_mem_rdata),
    .o_fail      (o_fail),
    .o_fail_addr (o_fail_addr),
    .o_fail_elem (o_fail_elem)
  );

  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = (r_state == ST_DONE);
  assign o_start_elem = w_startElem;
  assign o_dir_up     = r_dirUp;
  assign o_addr_step  = w_addrStep;
  assign o_mem_ce     = w_memCe;
  assign o_mem_we     = w_memWe;
  assign o_mem_wdata  = {DATA_WIDTH{w_wdataBit}};

endmodule
